// File: rtl/piso_tx_if.sv
// Load/ready word handshake in, registered bit stream out for piso_tx.
// Latency: n/a (signal bundle only).
// Backpressure: master holds load until it samples ready high at a rising edge.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d;
    logic             load;
    logic             ready;
    logic             sout;
    logic             frame;
    logic             done;

    modport master (
        output d, load,
        input  ready, sout, frame, done
    );

    modport slave (
        input  d, load,
        output ready, sout, frame, done
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter; optional even parity bit via `PISO_PARITY_EN.
// Latency: first bit on sout one cycle after the accepting edge; frame lasts FRAME_LEN cycles.
// Backpressure: ready only when idle or on the last bit; load while busy is ignored.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic      clk,
    input  logic      clr,
    piso_tx_if.slave  bus
);

`ifdef PISO_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    localparam int               FRAME_LEN = WIDTH + PAR_EN;
    localparam int               CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_par;
    logic             r_sout;
    logic             r_frame;
    logic             r_done;
    logic             r_ready;

    logic             w_accept;
    logic             w_stepping;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shifted;
    logic             w_par_slot;

    // ready is only ever high in IDLE or on the last bit, so an accept always starts a frame
    assign w_accept    = bus.load && r_ready;
    assign w_stepping  = (r_state == SHIFT) && (r_cnt != LAST);
    assign w_cnt_nxt   = r_cnt + CNT_W'(1);
    assign w_first_bit = (LSB_FIRST != 0) ? bus.d[0] : bus.d[WIDTH-1];
    assign w_next_bit  = (LSB_FIRST != 0) ? r_shreg[1] : r_shreg[WIDTH-2];
    assign w_shifted   = (LSB_FIRST != 0) ? {1'b0, r_shreg[WIDTH-1:1]}
                                          : {r_shreg[WIDTH-2:0], 1'b0};
    assign w_par_slot  = (PAR_EN != 0) && (w_cnt_nxt == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_sout  <= 1'b0;
            r_frame <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_shreg <= bus.d;
            r_cnt   <= '0;
            r_par   <= ^bus.d;
            r_sout  <= w_first_bit;
            r_frame <= 1'b1;
            r_done  <= (LAST == '0);
            r_ready <= (LAST == '0);
        end else if (w_stepping) begin
            r_state <= SHIFT;
            r_shreg <= w_shifted;
            r_cnt   <= w_cnt_nxt;
            r_sout  <= w_par_slot ? r_par : w_next_bit;
            r_frame <= 1'b1;
            r_done  <= (w_cnt_nxt == LAST);
            r_ready <= (w_cnt_nxt == LAST);
        end else begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_sout  <= 1'b0;
            r_frame <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end
    end

    assign bus.ready = r_ready;
    assign bus.sout  = r_sout;
    assign bus.frame = r_frame;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: LSB-first and MSB-first instances share stimulus and are
// checked each cycle against a queue-of-bits model, plus hand-computed frame literals.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int W  = 8;
    localparam int FL = W + PAR;

    logic         clk = 1'b0;
    logic         clr;
    logic         load;
    logic [W-1:0] d;

    int vectors;
    int miscompares;

    piso_tx_if #(.WIDTH(W)) if_l ();
    piso_tx_if #(.WIDTH(W)) if_m ();

    assign if_l.d    = d;
    assign if_l.load = load;
    assign if_m.d    = d;
    assign if_m.load = load;

    piso_tx #(.WIDTH(W), .LSB_FIRST(1)) dut_l (.clk(clk), .clr(clr), .bus(if_l));
    piso_tx #(.WIDTH(W), .LSB_FIRST(0)) dut_m (.clk(clk), .clr(clr), .bus(if_m));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each queue holds the bits still to appear on sout, front = current cycle.
    bit          q_l[$];
    bit          q_m[$];
    logic [63:0] log_l;
    logic [63:0] log_m;
    int          log_n;
    int          done_cnt;
    int          run_len;
    int          max_run;

    always @(posedge clk) begin : model
        bit rdy;
        rdy = (q_l.size() <= 1);
        if (clr) begin
            q_l.delete();
            q_m.delete();
        end else begin
            if (q_l.size() > 0) begin
                void'(q_l.pop_front());
                void'(q_m.pop_front());
            end
            if (load && rdy) begin
                for (int i = 0; i < W; i++) begin
                    q_l.push_back(d[i]);
                    q_m.push_back(d[W-1-i]);
                end
                if (PAR != 0) begin
                    q_l.push_back(^d);
                    q_m.push_back(^d);
                end
            end
        end
        #1;
        chk("l_frame", {31'b0, if_l.frame}, {31'b0, q_l.size() > 0});
        chk("l_sout",  {31'b0, if_l.sout},  {31'b0, (q_l.size() > 0) ? q_l[0] : 1'b0});
        chk("l_done",  {31'b0, if_l.done},  {31'b0, q_l.size() == 1});
        chk("l_ready", {31'b0, if_l.ready}, {31'b0, q_l.size() <= 1});
        chk("m_frame", {31'b0, if_m.frame}, {31'b0, q_m.size() > 0});
        chk("m_sout",  {31'b0, if_m.sout},  {31'b0, (q_m.size() > 0) ? q_m[0] : 1'b0});
        chk("m_done",  {31'b0, if_m.done},  {31'b0, q_m.size() == 1});
        chk("m_ready", {31'b0, if_m.ready}, {31'b0, q_m.size() <= 1});
        if (if_l.frame && log_n < 64) begin
            log_l[log_n] = if_l.sout;
            log_m[log_n] = if_m.sout;
            log_n++;
        end
        if (if_l.done) done_cnt++;
        run_len = if_l.frame ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        log_l    = '0;
        log_m    = '0;
        log_n    = 0;
        done_cnt = 0;
        max_run  = 0;
    endtask

    task automatic send(input logic [W-1:0] v);
        d    = v;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        clr         = 1'b1;
        load        = 1'b0;
        d           = '0;
        vectors     = 0;
        miscompares = 0;
        clear_logs();
        cyc(2);
        clr = 1'b0;
        cyc(1);
        chk("rst_ready", {31'b0, if_l.ready}, 32'h1);
        chk("rst_frame", {31'b0, if_l.frame}, 32'h0);
        chk("rst_sout",  {31'b0, if_l.sout},  32'h0);

        // Single frame of 0x1F
        clear_logs();
        send(8'h1F);
        cyc(FL + 3);
        chk("t1_lsb_bits", log_l[31:0], (PAR != 0) ? 32'h11F : 32'h1F);
        chk("t1_msb_bits", log_m[31:0], (PAR != 0) ? 32'h1F8 : 32'hF8);
        chk("t1_len",      log_n,       FL);
        chk("t1_done_cnt", done_cnt,    1);
        chk("t1_idle_rdy", {31'b0, if_l.ready}, 32'h1);

        // Back-to-back: second load held in the done cycle
        clear_logs();
        send(8'h01);
        cyc(FL - 1);
        chk("b2b_done_now", {31'b0, if_l.done},  32'h1);
        chk("b2b_rdy_now",  {31'b0, if_l.ready}, 32'h1);
        d    = 8'h80;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(FL + 3);
        chk("b2b_lsb_bits", log_l[31:0], (PAR != 0) ? 32'h30101 : 32'h8001);
        chk("b2b_msb_bits", log_m[31:0], (PAR != 0) ? 32'h20380 : 32'h0180);
        chk("b2b_run",      max_run,     2 * FL);
        chk("b2b_done_cnt", done_cnt,    2);

        // Load pulse at bit 3 while busy must be ignored
        clear_logs();
        send(8'hFF);
        cyc(2);
        d    = 8'h00;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(FL + 3);
        chk("busy_bits",     log_l[31:0], (PAR != 0) ? 32'h0FF : 32'hFF);
        chk("busy_len",      log_n,       FL);
        chk("busy_done_cnt", done_cnt,    1);

        // Reset during bit 4 aborts the frame
        clear_logs();
        send(8'hAA);
        cyc(3);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("abort_frame", {31'b0, if_l.frame}, 32'h0);
        chk("abort_sout",  {31'b0, if_l.sout},  32'h0);
        chk("abort_ready", {31'b0, if_l.ready}, 32'h1);
        cyc(3);
        chk("abort_len",      log_n,      4);
        chk("abort_lsb_bits", log_l[3:0], 4'hA);
        chk("abort_msb_bits", log_m[3:0], 4'h5);
        chk("abort_done_cnt", done_cnt,   0);

        // Parity-sensitive words: 0x07 (odd ones), 0x03 (even ones)
        clear_logs();
        send(8'h07);
        cyc(FL + 3);
        chk("p07_lsb_bits", log_l[31:0], (PAR != 0) ? 32'h107 : 32'h07);
        chk("p07_msb_bits", log_m[31:0], (PAR != 0) ? 32'h1E0 : 32'hE0);
        chk("p07_done_cnt", done_cnt,    1);
        clear_logs();
        send(8'h03);
        cyc(FL + 3);
        chk("p03_lsb_bits", log_l[31:0], 32'h03);
        chk("p03_msb_bits", log_m[31:0], 32'hC0);
        chk("p03_len",      log_n,       FL);

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
